// File: rtl/demux_1n_reg_if.sv
// Handshake bundle for demux_1n_reg: one producer-side input port fanning out to N registered channels.
// The master modport is the environment, and the slave modport is the demux itself.
interface demux_1n_reg_if #(
    parameter int W = 8,
    parameter int N = 16
);
    localparam int SW = $clog2(N);

    logic           e;
    logic           mode;
    logic [SW-1:0]  s;
    logic [W-1:0]   i_data;
    logic           i_valid;
    logic           i_ready;
    logic [N*W-1:0] y_data;
    logic [N-1:0]   y_valid;
    logic [N-1:0]   y_ready;
    logic [SW-1:0]  cur_s;
    logic           sel_err;

    modport master (
        output e, mode, s, i_data, i_valid, y_ready,
        input  i_ready, y_data, y_valid, cur_s, sel_err
    );

    modport slave (
        input  e, mode, s, i_data, i_valid, y_ready,
        output i_ready, y_data, y_valid, cur_s, sel_err
    );
endinterface

// File: rtl/demux_1n_reg.sv
// 1-to-N demultiplexer with a one-entry output register per channel and direct or auto-scan target select.
// Optional feature macro DEMUX_BCAST_EN adds a bcast input that writes one word into every channel.
module demux_1n_reg #(
    parameter int W = 8,
    parameter int N = 16
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef DEMUX_BCAST_EN
    input  logic          bcast,
`endif
    demux_1n_reg_if.slave bus
);
    localparam int            SW    = $clog2(N);
    localparam logic [SW:0]   N_EXT = (SW+1)'(N);

    logic [SW-1:0]  scan_r;
    logic [N-1:0]   y_valid_r;
    logic [N*W-1:0] y_data_r;
    logic           sel_err_r;

    logic [SW-1:0]  tgt_s;
    logic           tgt_in_range_s;
    logic [N-1:0]   free_s;
    logic [N-1:0]   hit_s;
    logic           tgt_free_s;
    logic           all_free_s;
    logic           bcast_s;
    logic           i_ready_s;
    logic           xfer_s;
    logic [N-1:0]   load_s;

    // Broadcast request, tied off when the feature is not built
    always_comb begin
`ifdef DEMUX_BCAST_EN
        bcast_s = bcast;
`else
        bcast_s = 1'b0;
`endif
    end

    // Target selection, per-channel availability and transfer decode
    always_comb begin
        tgt_s          = bus.mode ? scan_r : bus.s;
        tgt_in_range_s = ({1'b0, tgt_s} < N_EXT);
        free_s         = {N{1'b0}};
        hit_s          = {N{1'b0}};
        for (int k = 0; k < N; k++) begin
            // A slot is usable when empty or being drained on this same edge
            free_s[k] = !y_valid_r[k] || bus.y_ready[k];
            hit_s[k]  = (tgt_s == SW'(k));
        end
        tgt_free_s = |(free_s & hit_s);
        all_free_s = &free_s;
        i_ready_s  = !bus.e && (bcast_s ? all_free_s : (tgt_in_range_s && tgt_free_s));
        xfer_s     = bus.i_valid && i_ready_s;
        load_s     = bcast_s ? {N{xfer_s}} : (hit_s & {N{xfer_s}});
    end

    // Channel registers: load wins over drain so a full slot refills without a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid_r <= {N{1'b0}};
            y_data_r  <= {(N*W){1'b0}};
        end else begin
            for (int k = 0; k < N; k++) begin
                if (load_s[k]) begin
                    y_valid_r[k]       <= 1'b1;
                    y_data_r[k*W +: W] <= bus.i_data;
                end else if (y_valid_r[k] && bus.y_ready[k]) begin
                    y_valid_r[k] <= 1'b0;
                end else begin
                    y_valid_r[k] <= y_valid_r[k];
                end
            end
        end
    end

    // Scan counter steps only on single-channel transfers taken in scan mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_r <= {SW{1'b0}};
        end else if (xfer_s && bus.mode && !bcast_s) begin
            scan_r <= (scan_r == SW'(N-1)) ? {SW{1'b0}} : (scan_r + SW'(1));
        end else begin
            scan_r <= scan_r;
        end
    end

    // Sticky out-of-range select flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_r <= 1'b0;
        end else if (bus.i_valid && !bcast_s && !tgt_in_range_s) begin
            sel_err_r <= 1'b1;
        end else begin
            sel_err_r <= sel_err_r;
        end
    end

    assign bus.i_ready = i_ready_s;
    assign bus.y_valid = y_valid_r;
    assign bus.y_data  = y_data_r;
    assign bus.cur_s   = tgt_s;
    assign bus.sel_err = sel_err_r;
endmodule
